s_axil_register_file: RTL

- Synthesizable AXI4-Lite slave: a bank of NUM_REG read/write registers, each S_AXI_DATA_WIDTH bits wide.
- It is the responder side of the AXI-Lite master register BFM and is the DUT that BFM drives.
- Write and read channels operate independently, with one outstanding transaction per direction.
- Handles any AW/W arrival order and any READY/VALID stall pattern the master produces.

---
 rtl/axil_pkg.sv | 23 ++
 rtl/axil_addr_decode.sv | 21 ++
 rtl/s_axil_register_file.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/axil_pkg.sv
// rtl/axil_pkg.sv - shared AXI4-Lite response codes, FSM state types and address helpers.
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic {
      WR_ACCEPT,
      WR_RESP
   } wr_state_e;

   typedef enum logic {
      RD_ACCEPT,
      RD_RESP
   } rd_state_e;

   function automatic int addr_lsb(input int data_width);
      return $clog2(data_width / 8);
   endfunction

endpackage

// File: rtl/axil_addr_decode.sv
// rtl/axil_addr_decode.sv - byte address to register index and in-range flag.
module axil_addr_decode
   import axil_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REG    = 16,
   localparam int IDX_W     = $clog2(NUM_REG)
) (
   input  logic [ADDR_WIDTH-1:0] addr_i,
   output logic [IDX_W-1:0]      index_o,
   output logic                  in_range_o
);

   localparam int ADDR_LSB = addr_lsb(DATA_WIDTH);
   localparam int HI_LSB   = ADDR_LSB + IDX_W;

   assign index_o    = addr_i[ADDR_LSB +: IDX_W];
   assign in_range_o = ((addr_i >> HI_LSB) == '0);

endmodule

// File: rtl/s_axil_register_file.sv
// rtl/s_axil_register_file.sv - AXI4-Lite slave bank of NUM_REG read/write registers.
// Define AXIL_REG_ERR_RESP_EN to answer out-of-range accesses with SLVERR instead of aliasing.
module s_axil_register_file #(
   parameter int S_AXI_DATA_WIDTH = 32,
   parameter int S_AXI_ADDR_WIDTH = 32,
   parameter int NUM_REG          = 16
) (
   input  logic                          ACLK,
   input  logic                          ARESET,
   input  logic [S_AXI_ADDR_WIDTH-1:0]   AWADDR,
   input  logic                          AWVALID,
   output logic                          AWREADY,
   input  logic [S_AXI_DATA_WIDTH-1:0]   WDATA,
   input  logic [S_AXI_DATA_WIDTH/8-1:0] WSTRB,
   input  logic                          WVALID,
   output logic                          WREADY,
   output logic [1:0]                    BRESP,
   output logic                          BVALID,
   input  logic                          BREADY,
   input  logic [S_AXI_ADDR_WIDTH-1:0]   ARADDR,
   input  logic                          ARVALID,
   output logic                          ARREADY,
   output logic [S_AXI_DATA_WIDTH-1:0]   RDATA,
   output logic [1:0]                    RRESP,
   output logic                          RVALID,
   input  logic                          RREADY
);
   import axil_pkg::*;

   localparam int IDX_W  = $clog2(NUM_REG);
   localparam int STRB_W = S_AXI_DATA_WIDTH / 8;
`ifdef AXIL_REG_ERR_RESP_EN
   localparam bit ERR_RESP_EN = 1'b1;
`else
   localparam bit ERR_RESP_EN = 1'b0;
`endif

   logic [S_AXI_DATA_WIDTH-1:0] regs_q [NUM_REG];
   wr_state_e                   wr_state_q, wr_state_d;
   rd_state_e                   rd_state_q, rd_state_d;
   logic                        rdy_en_q;
   logic                        aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [IDX_W-1:0]            aw_idx_q, aw_idx_d;
   logic                        aw_ok_q, aw_ok_d;
   logic [S_AXI_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]           wstrb_q, wstrb_d;
   logic                        bvalid_q, bvalid_d;
   logic [1:0]                  bresp_q, bresp_d;
   logic                        rvalid_q, rvalid_d;
   logic [1:0]                  rresp_q, rresp_d;
   logic [S_AXI_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                        reg_we;
   logic [IDX_W-1:0]            aw_dec_idx, ar_dec_idx;
   logic                        aw_dec_ok, ar_dec_ok;
   logic                        awready, wready, arready;

   axil_addr_decode #(.ADDR_WIDTH(S_AXI_ADDR_WIDTH), .DATA_WIDTH(S_AXI_DATA_WIDTH), .NUM_REG(NUM_REG))
      u_aw_decode (.addr_i(AWADDR), .index_o(aw_dec_idx), .in_range_o(aw_dec_ok));
   axil_addr_decode #(.ADDR_WIDTH(S_AXI_ADDR_WIDTH), .DATA_WIDTH(S_AXI_DATA_WIDTH), .NUM_REG(NUM_REG))
      u_ar_decode (.addr_i(ARADDR), .index_o(ar_dec_idx), .in_range_o(ar_dec_ok));

   // rdy_en_q keeps every READY low until the first edge after reset releases.
   assign awready = rdy_en_q && (wr_state_q == WR_ACCEPT) && !aw_held_q;
   assign wready  = rdy_en_q && (wr_state_q == WR_ACCEPT) && !w_held_q;
   assign arready = rdy_en_q && (rd_state_q == RD_ACCEPT);

   always_comb begin
      wr_state_d = wr_state_q;
      aw_held_d  = aw_held_q;
      w_held_d   = w_held_q;
      aw_idx_d   = aw_idx_q;
      aw_ok_d    = aw_ok_q;
      wdata_d    = wdata_q;
      wstrb_d    = wstrb_q;
      bvalid_d   = bvalid_q;
      bresp_d    = bresp_q;
      reg_we     = 1'b0;
      unique case (wr_state_q)
         WR_ACCEPT: begin
            if (aw_held_q && w_held_q) begin
               reg_we     = aw_ok_q;
               bvalid_d   = 1'b1;
               bresp_d    = aw_ok_q ? RESP_OKAY : RESP_SLVERR;
               aw_held_d  = 1'b0;
               w_held_d   = 1'b0;
               wr_state_d = WR_RESP;
            end else begin
               if (AWVALID && awready) begin
                  aw_held_d = 1'b1;
                  aw_idx_d  = aw_dec_idx;
                  aw_ok_d   = !ERR_RESP_EN || aw_dec_ok;
               end
               if (WVALID && wready) begin
                  w_held_d = 1'b1;
                  wdata_d  = WDATA;
                  wstrb_d  = WSTRB;
               end
            end
         end
         WR_RESP: begin
            if (BREADY) begin
               bvalid_d   = 1'b0;
               wr_state_d = WR_ACCEPT;
            end
         end
      endcase
   end

   // regs_q is sampled before this edge's commit, so a colliding read sees the old value.
   always_comb begin
      rd_state_d = rd_state_q;
      rvalid_d   = rvalid_q;
      rresp_d    = rresp_q;
      rdata_d    = rdata_q;
      unique case (rd_state_q)
         RD_ACCEPT: begin
            if (ARVALID && arready) begin
               rd_state_d = RD_RESP;
               rvalid_d   = 1'b1;
               if (!ERR_RESP_EN || ar_dec_ok) begin
                  rdata_d = regs_q[ar_dec_idx];
                  rresp_d = RESP_OKAY;
               end else begin
                  rdata_d = '0;
                  rresp_d = RESP_SLVERR;
               end
            end
         end
         RD_RESP: begin
            if (RREADY) begin
               rvalid_d   = 1'b0;
               rd_state_d = RD_ACCEPT;
            end
         end
      endcase
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_state_q <= WR_ACCEPT;
         rd_state_q <= RD_ACCEPT;
         rdy_en_q   <= 1'b0;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         aw_idx_q   <= '0;
         aw_ok_q    <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= RESP_OKAY;
         rvalid_q   <= 1'b0;
         rresp_q    <= RESP_OKAY;
         rdata_q    <= '0;
      end else begin
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
         rdy_en_q   <= 1'b1;
         aw_held_q  <= aw_held_d;
         w_held_q   <= w_held_d;
         aw_idx_q   <= aw_idx_d;
         aw_ok_q    <= aw_ok_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
      end
   end

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         for (int r = 0; r < NUM_REG; r++) regs_q[r] <= '0;
      end else if (reg_we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb_q[b]) regs_q[aw_idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
         end
      end
   end

   assign AWREADY = awready;
   assign WREADY  = wready;
   assign ARREADY = arready;
   assign BVALID  = bvalid_q;
   assign BRESP   = bresp_q;
   assign RVALID  = rvalid_q;
   assign RRESP   = rresp_q;
   assign RDATA   = rdata_q;

endmodule
